fetch_unit_46: RTL and testbench
================================

# fetch_unit_46

Instruction-fetch stage of the five-stage 32-bit MIPS pipeline, directly upstream of the instruction memory. After reset it runs a boot loader that streams program words into the instruction memory's write port. It then owns the program counter, drives the memory read address, and captures returned instructions into the IF/ID pipeline register, honouring stall, flush and branch/jump redirect from later stages.

## Interface

- RESET_PC, 32'h00000000, PC value on entering RUN
- NOP_INSTR, 32'h0000003F, NOP encoding inserted into IF/ID on flush/reset
- LOAD_LIMIT, 32'd2000, highest byte address the loader may write
- clk_46  in  1  system clock, all state updates on rising edge
- rst_46  in  1  reset, asynchronous, active-high
- ld_valid_46  in  1  loader word present
- ld_data_46  in  32  loader word
- ld_last_46  in  1  qualifies final loader word
- ld_ready_46  out  1  loader word accepted this cycle (state==LOAD)
- imem_waddr_46  out  32  instruction memory write address
- imem_wdata_46  out  32  instruction memory write data
- imem_write_46  out  1  instruction memory write enable
- imem_raddr_46  out  32  instruction memory read address (= PC)
- imem_rdata_46  in  32  instruction memory read data (combinational from raddr)
- stall_46  in  1  hold PC and IF/ID (hazard unit)
- flush_46  in  1  squash IF/ID contents
- redirect_46  in  1  take branch/jump
- redirect_pc_46  in  32  branch/jump target
- ifid_instr_46  out  32  IF/ID instruction
- ifid_pc4_46  out  32  IF/ID PC+4
- ifid_valid_46  out  1  IF/ID holds a real instruction
- running_46  out  1  state==RUN

## Operation

- Registers: state {LOAD, RUN}, load pointer lp, pc, ifid_instr, ifid_pc4, ifid_valid.
- Reset (async, immediate): state=LOAD, lp=0, pc=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc4=0, ifid_valid=0. Outputs after reset: ld_ready=1, running=0, imem_write=0, imem_raddr=RESET_PC.
- LOAD:
  - ld_ready=1; imem_write=ld_valid; imem_waddr=lp; imem_wdata=ld_data (combinational; memory captures on the same edge).
  - On accepted word (ld_valid): lp<=lp+4.
  - If accepted word has ld_last=1 or lp==LOAD_LIMIT: state<=RUN, lp<=0.
  - ld_valid=0: no write, no change.
  - stall/flush/redirect ignored; IF/ID holds reset values; pc holds RESET_PC.
- RUN:
  - ld_ready=0, imem_write=0; loader inputs ignored.
  - imem_raddr=pc. Per-edge priority:
    1. redirect: pc<={redirect_pc[31:2],2'b00}; ifid_instr<=NOP_INSTR, ifid_valid<=0, ifid_pc4 holds. Overrides stall and flush.
    2. else stall and flush: pc holds; IF/ID<=NOP_INSTR, valid 0.
    3. else stall: pc and IF/ID hold.
    4. else flush: pc<=pc+4; IF/ID<=NOP_INSTR, valid 0.
    5. else: pc<=pc+4; ifid_instr<=imem_rdata, ifid_pc4<=pc+4, ifid_valid<=1.
  - RUN is terminal until reset.
- Arithmetic: pc+4 and lp+4 are 32-bit modulo (0xFFFFFFFC wraps to 0). pc bits [1:0] are always 0.

## Timing

- Fetch latency: instruction at address A appears on ifid_instr one edge after pc==A.
- Redirect penalty: one bubble (valid=0) when redirect is asserted, then target fetched the next cycle; target instruction reaches IF/ID two edges after redirect.
- LOAD->RUN: first fetch cycle is the cycle after the last word's edge; first valid IF/ID one edge later.
- Reset asserted mid-load or mid-run: immediate return to reset values; loading restarts at address 0.

## Test plan

- Reset then load 4 words (0x0000003F, 0x00800684, 0x00C00F04, 0x01000204, last on 4th) -> writes at 0,4,8,12; running=1 next cycle; ifid_instr sequence 0x0000003F, 0x00800684, ... with ifid_pc4 = 4, 8, 12.
- Gapped loader (ld_valid toggling) -> no write or lp advance on idle cycles; lp never exceeds LOAD_LIMIT; word at 2000 forces RUN.
- stall for 3 cycles at pc=8 -> pc stays 8, IF/ID unchanged 3 cycles, then resumes with pc=12.
- redirect to 0x31 with stall=1 -> pc=0x30 next edge, one NOP bubble with valid=0, then instruction at 0x30.
- flush alone at pc=16 -> IF/ID=NOP_INSTR valid=0, pc=20; stall+flush -> pc holds, IF/ID NOP.
- Assert rst_46 mid-RUN between edges -> outputs return to reset values immediately; state=LOAD, ld_ready=1.

Source files
------------

// File: rtl/fetch_unit_46.sv
// Instruction-fetch stage: a boot loader streams words into instruction memory,
// then the stage owns the PC and fills the IF/ID register (stall/flush/redirect).
module fetch_unit_46 #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_003F,
  parameter logic [31:0] LOAD_LIMIT = 32'd2000
) (
  input  logic        clk_46,
  input  logic        rst_46,
  input  logic        ld_valid_46,
  input  logic [31:0] ld_data_46,
  input  logic        ld_last_46,
  output logic        ld_ready_46,
  output logic [31:0] imem_waddr_46,
  output logic [31:0] imem_wdata_46,
  output logic        imem_write_46,
  output logic [31:0] imem_raddr_46,
  input  logic [31:0] imem_rdata_46,
  input  logic        stall_46,
  input  logic        flush_46,
  input  logic        redirect_46,
  input  logic [31:0] redirect_pc_46,
  output logic [31:0] ifid_instr_46,
  output logic [31:0] ifid_pc4_46,
  output logic        ifid_valid_46,
  output logic        running_46
);

  typedef enum logic {LOAD, RUN} state_t;

  state_t      state_reg, state_next;
  logic [31:0] lp_reg, lp_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] ifid_instr_reg, ifid_instr_next;
  logic [31:0] ifid_pc4_reg, ifid_pc4_next;
  logic        ifid_valid_reg, ifid_valid_next;

  logic [31:0] pc_plus4;
  logic [31:0] lp_plus4;
  logic [31:0] redirect_aligned;

  assign pc_plus4         = pc_reg + 32'd4;
  assign lp_plus4         = lp_reg + 32'd4;
  assign redirect_aligned = redirect_pc_46 & 32'hFFFF_FFFC;

  always_ff @(posedge clk_46 or posedge rst_46) begin
    if (rst_46) begin
      state_reg      <= LOAD;
      lp_reg         <= 32'd0;
      pc_reg         <= RESET_PC;
      ifid_instr_reg <= NOP_INSTR;
      ifid_pc4_reg   <= 32'd0;
      ifid_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      lp_reg         <= lp_next;
      pc_reg         <= pc_next;
      ifid_instr_reg <= ifid_instr_next;
      ifid_pc4_reg   <= ifid_pc4_next;
      ifid_valid_reg <= ifid_valid_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    lp_next         = lp_reg;
    pc_next         = pc_reg;
    ifid_instr_next = ifid_instr_reg;
    ifid_pc4_next   = ifid_pc4_reg;
    ifid_valid_next = ifid_valid_reg;
    ld_ready_46     = 1'b0;
    imem_write_46   = 1'b0;

    case (state_reg)
      LOAD: begin
        ld_ready_46   = 1'b1;
        imem_write_46 = ld_valid_46;
        if (ld_valid_46) begin
          lp_next = lp_plus4;
          // The word landing on LOAD_LIMIT is the last one we may accept.
          if (ld_last_46 || (lp_reg == LOAD_LIMIT)) begin
            state_next = RUN;
            lp_next    = 32'd0;
          end
        end
      end
      RUN: begin
        if (redirect_46) begin
          pc_next         = redirect_aligned;
          ifid_instr_next = NOP_INSTR;
          ifid_valid_next = 1'b0;
        end else if (stall_46 && flush_46) begin
          ifid_instr_next = NOP_INSTR;
          ifid_valid_next = 1'b0;
        end else if (stall_46) begin
          // hold everything
        end else if (flush_46) begin
          pc_next         = pc_plus4;
          ifid_instr_next = NOP_INSTR;
          ifid_valid_next = 1'b0;
        end else begin
          pc_next         = pc_plus4;
          ifid_instr_next = imem_rdata_46;
          ifid_pc4_next   = pc_plus4;
          ifid_valid_next = 1'b1;
        end
      end
      default: state_next = LOAD;
    endcase
  end

  assign imem_waddr_46 = lp_reg;
  assign imem_wdata_46 = ld_data_46;
  assign imem_raddr_46 = pc_reg;
  assign ifid_instr_46 = ifid_instr_reg;
  assign ifid_pc4_46   = ifid_pc4_reg;
  assign ifid_valid_46 = ifid_valid_reg;
  assign running_46    = (state_reg == RUN);

endmodule

// File: tb/tb_fetch_unit_46.sv
// Directed bench for fetch_unit_46: loader, fetch/stall/flush/redirect, async reset.
module tb_fetch_unit_46;

  logic        clk_46 = 1'b0;
  logic        rst_46;
  logic        ld_valid_46 = 1'b0;
  logic [31:0] ld_data_46 = 32'd0;
  logic        ld_last_46 = 1'b0;
  logic        ld_ready_46;
  logic [31:0] imem_waddr_46, imem_wdata_46, imem_raddr_46, imem_rdata_46;
  logic        imem_write_46;
  logic        stall_46 = 1'b0, flush_46 = 1'b0, redirect_46 = 1'b0;
  logic [31:0] redirect_pc_46 = 32'd0;
  logic [31:0] ifid_instr_46, ifid_pc4_46;
  logic        ifid_valid_46, running_46;

  localparam logic [31:0] NOP = 32'h0000_003F;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } exp_t;

  exp_t sb[$];
  int n_total = 0;
  int n_fail  = 0;

  logic [31:0] mem [0:1023];
  logic [31:0] boot [0:3];

  always #5 clk_46 = ~clk_46;

  always @(posedge clk_46)
    if (imem_write_46) mem[imem_waddr_46[11:2]] <= imem_wdata_46;

  assign imem_rdata_46 = mem[imem_raddr_46[11:2]];

  fetch_unit_46 dut (
    .clk_46(clk_46), .rst_46(rst_46),
    .ld_valid_46(ld_valid_46), .ld_data_46(ld_data_46), .ld_last_46(ld_last_46),
    .ld_ready_46(ld_ready_46),
    .imem_waddr_46(imem_waddr_46), .imem_wdata_46(imem_wdata_46),
    .imem_write_46(imem_write_46),
    .imem_raddr_46(imem_raddr_46), .imem_rdata_46(imem_rdata_46),
    .stall_46(stall_46), .flush_46(flush_46),
    .redirect_46(redirect_46), .redirect_pc_46(redirect_pc_46),
    .ifid_instr_46(ifid_instr_46), .ifid_pc4_46(ifid_pc4_46),
    .ifid_valid_46(ifid_valid_46), .running_46(running_46)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ld_ready"},   {31'd0, ld_ready_46},   32'd1);
    chk({tag, "_running"},    {31'd0, running_46},    32'd0);
    chk({tag, "_imem_write"}, {31'd0, imem_write_46}, 32'd0);
    chk({tag, "_raddr"},      imem_raddr_46,          32'd0);
    chk({tag, "_ifid_instr"}, ifid_instr_46,          NOP);
    chk({tag, "_ifid_pc4"},   ifid_pc4_46,            32'd0);
    chk({tag, "_ifid_valid"}, {31'd0, ifid_valid_46}, 32'd0);
  endtask

  // One loader cycle: check the write port combinationally, then clock it.
  task automatic load_cyc(input logic v, input logic [31:0] d, input logic last,
                          input logic [31:0] exp_addr, input logic exp_run);
    ld_valid_46 = v; ld_data_46 = d; ld_last_46 = last;
    #1;
    chk("ld_write", {31'd0, imem_write_46}, {31'd0, v});
    chk("ld_waddr", imem_waddr_46, exp_addr);
    if (v) chk("ld_wdata", imem_wdata_46, d);
    @(posedge clk_46); #1;
    ld_valid_46 = 1'b0; ld_last_46 = 1'b0;
    chk("ld_running", {31'd0, running_46}, {31'd0, exp_run});
    $display("load v=%0b addr=%h data=%h last=%0b running=%0b", v, exp_addr, d, last, running_46);
  endtask

  // One run cycle: expected result queued when stimulus is driven, popped after the edge.
  task automatic cyc(input logic st, input logic fl, input logic rd, input logic [31:0] rpc,
                     input logic [31:0] e_pc, input logic [31:0] e_instr,
                     input logic [31:0] e_pc4, input logic e_valid);
    exp_t e;
    stall_46 = st; flush_46 = fl; redirect_46 = rd; redirect_pc_46 = rpc;
    sb.push_back('{pc: e_pc, instr: e_instr, pc4: e_pc4, valid: e_valid});
    @(posedge clk_46); #1;
    stall_46 = 1'b0; flush_46 = 1'b0; redirect_46 = 1'b0;
    e = sb.pop_front();
    chk("run_pc", imem_raddr_46, e.pc);
    chk("run_instr", ifid_instr_46, e.instr);
    chk("run_valid", {31'd0, ifid_valid_46}, {31'd0, e.valid});
    if (e.valid) chk("run_pc4", ifid_pc4_46, e.pc4);
    $display("run st=%0b fl=%0b rd=%0b pc=%h instr=%h pc4=%h valid=%0b",
             st, fl, rd, imem_raddr_46, ifid_instr_46, ifid_pc4_46, ifid_valid_46);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + i;
    boot[0] = 32'h0000_003F; boot[1] = 32'h0080_0684;
    boot[2] = 32'h00C0_0F04; boot[3] = 32'h0100_0204;

    rst_46 = 1'b1;
    @(posedge clk_46); #1;
    chk_reset_outputs("reset");
    rst_46 = 1'b0;

    // Boot load with one idle cycle (ld_last high but invalid must be ignored).
    load_cyc(1'b1, boot[0], 1'b0, 32'd0, 1'b0);
    load_cyc(1'b0, 32'hDEAD_BEEF, 1'b1, 32'd4, 1'b0);
    load_cyc(1'b1, boot[1], 1'b0, 32'd4, 1'b0);
    load_cyc(1'b1, boot[2], 1'b0, 32'd8, 1'b0);
    load_cyc(1'b1, boot[3], 1'b1, 32'd12, 1'b1);
    chk("run_ld_ready", {31'd0, ld_ready_46}, 32'd0);
    chk("run_first_pc", imem_raddr_46, 32'd0);
    chk("run_ifid_idle", {31'd0, ifid_valid_46}, 32'd0);

    // Loader inputs are ignored in RUN.
    ld_valid_46 = 1'b1; ld_last_46 = 1'b1;
    #1;
    chk("run_no_write", {31'd0, imem_write_46}, 32'd0);
    cyc(0, 0, 0, 0, 32'd4, boot[0], 32'd4, 1);
    ld_valid_46 = 1'b0; ld_last_46 = 1'b0;
    cyc(0, 0, 0, 0, 32'd8, boot[1], 32'd8, 1);
    // Stall three cycles at pc=8.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 32'd8, boot[1], 32'd8, 1);
    cyc(0, 0, 0, 0, 32'd12, boot[2], 32'd12, 1);
    cyc(0, 0, 0, 0, 32'd16, boot[3], 32'd16, 1);
    // Flush alone at pc=16, then a normal fetch, then stall+flush.
    cyc(0, 1, 0, 0, 32'd20, NOP, 32'd0, 0);
    cyc(0, 0, 0, 0, 32'd24, 32'hA000_0005, 32'd24, 1);
    cyc(1, 1, 0, 0, 32'd24, NOP, 32'd0, 0);
    // Redirect to 0x31 wins over stall; one bubble, then target instruction.
    cyc(1, 0, 1, 32'h31, 32'h30, NOP, 32'd0, 0);
    chk("redir_pc4_hold", ifid_pc4_46, 32'd24);
    cyc(0, 0, 0, 0, 32'h34, 32'hA000_000C, 32'h34, 1);
    // Redirect with flush to the top of memory; pc+4 wraps to 0.
    cyc(0, 1, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, NOP, 32'd0, 0);
    cyc(0, 0, 0, 0, 32'd0, 32'hA000_03FF, 32'd0, 1);
    cyc(0, 0, 0, 0, 32'd4, boot[0], 32'd4, 1);

    // Asynchronous reset between edges.
    rst_46 = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    @(posedge clk_46); #1;
    rst_46 = 1'b0;

    // Gapped stream up to LOAD_LIMIT with no ld_last; the word at 2000 ends loading.
    for (int a = 0; a <= 2000; a += 4) begin
      load_cyc(1'b0, 32'h0, 1'b0, a, 1'b0);
      load_cyc(1'b1, 32'hB000_0000 + a, 1'b0, a, (a == 2000));
    end
    chk("limit_lp_reset", imem_waddr_46, 32'd0);
    cyc(0, 0, 0, 0, 32'd4, 32'hB000_0000, 32'd4, 1);
    cyc(0, 0, 0, 0, 32'd8, 32'hB000_0004, 32'd8, 1);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
